// File: rtl/program_counter_rs.sv
// Program counter with condition/update-style decode and a LIFO return-address
// stack for call/return. All outputs are registered; stall freezes everything.
module program_counter_rs #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 16,
    parameter int HALF_OFF_WIDTH = 4,
    parameter int STACK_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic [1:0]                     BC,
    input  logic [2:0]                     PS,
    input  logic [DATA_WIDTH-1:0]          D,
    input  logic [DATA_WIDTH-1:0]          A,
    input  logic [HALF_OFF_WIDTH-1:0]      AA,
    input  logic [HALF_OFF_WIDTH-1:0]      BA,
    output logic [ADDR_WIDTH-1:0]          pc,
    output logic [$clog2(STACK_DEPTH):0]   stack_count,
    output logic                           stack_overflow,
    output logic                           stack_underflow
);

    localparam int PW    = $clog2(STACK_DEPTH);
    localparam int CW    = PW + 1;
    localparam int OFF_W = 2 * HALF_OFF_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);
    localparam logic [CW-1:0]         CNT_ONE = CW'(1);
    localparam logic [CW-1:0]         CNT_FULL = CW'(STACK_DEPTH);

    localparam logic [1:0] BC_ZERO = 2'd0;
    localparam logic [1:0] BC_NZERO = 2'd1;
    localparam logic [1:0] BC_NEG  = 2'd2;

    localparam logic [2:0] PS_HOLD     = 3'd0;
    localparam logic [2:0] PS_INC      = 3'd1;
    localparam logic [2:0] PS_REL      = 3'd2;
    localparam logic [2:0] PS_ABS      = 3'd3;
    localparam logic [2:0] PS_CALL_REL = 3'd4;
    localparam logic [2:0] PS_CALL_ABS = 3'd5;
    localparam logic [2:0] PS_RET      = 3'd6;

    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [OFF_W-1:0]      offset;
    logic [ADDR_WIDTH-1:0] off_ext;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] rel_tgt;
    logic [ADDR_WIDTH-1:0] abs_tgt;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [CW-1:0]         cnt_m1;
    logic [CW-1:0]         cnt_nxt;
    logic                  taken;
    logic                  push;
    logic                  ovf_set;
    logic                  unf_set;

    assign offset = {AA, BA};

    // Offset is sign-extended when narrower than the PC, otherwise truncated.
    generate
        if (OFF_W >= ADDR_WIDTH) begin : g_off_trunc
            assign off_ext = offset[ADDR_WIDTH-1:0];
        end else begin : g_off_sext
            assign off_ext = {{(ADDR_WIDTH-OFF_W){offset[OFF_W-1]}}, offset};
        end
        if (DATA_WIDTH > ADDR_WIDTH) begin : g_a_upper
            logic unused_a_upper;
            assign unused_a_upper = ^A[DATA_WIDTH-1:ADDR_WIDTH];
        end
    endgenerate

    always_comb begin
        pc_inc  = pc + PC_ONE;
        rel_tgt = pc + off_ext + PC_ONE;
        abs_tgt = A[ADDR_WIDTH-1:0];
        cnt_m1  = stack_count - CNT_ONE;

        case (BC)
            BC_ZERO:  taken = (D == '0);
            BC_NZERO: taken = (D != '0);
            BC_NEG:   taken = D[DATA_WIDTH-1];
            default:  taken = 1'b1;
        endcase

        pc_nxt  = pc_inc;
        cnt_nxt = stack_count;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        if (taken) begin
            case (PS)
                PS_HOLD: pc_nxt = pc;
                PS_INC:  pc_nxt = pc_inc;
                PS_REL:  pc_nxt = rel_tgt;
                PS_ABS:  pc_nxt = abs_tgt;
                PS_CALL_REL, PS_CALL_ABS: begin
                    // A call into a full stack is dropped and falls through.
                    if (stack_count == CNT_FULL) begin
                        ovf_set = 1'b1;
                    end else begin
                        push    = 1'b1;
                        cnt_nxt = stack_count + CNT_ONE;
                        pc_nxt  = (PS == PS_CALL_REL) ? rel_tgt : abs_tgt;
                    end
                end
                PS_RET: begin
                    if (stack_count == '0) begin
                        unf_set = 1'b1;
                    end else begin
                        pc_nxt  = stack_mem[cnt_m1[PW-1:0]];
                        cnt_nxt = cnt_m1;
                    end
                end
                default: pc_nxt = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc              <= '0;
            stack_count     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (!stall) begin
            pc          <= pc_nxt;
            stack_count <= cnt_nxt;
            if (ovf_set) stack_overflow  <= 1'b1;
            if (unf_set) stack_underflow <= 1'b1;
        end
    end

    // Stack contents need no reset; only entries below stack_count are ever read.
    always_ff @(posedge clk) begin
        if (!reset && !stall && push) begin
            stack_mem[stack_count[PW-1:0]] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_program_counter_rs.sv
// Directed bench for program_counter_rs: the driver pushes hand-computed expected
// state into a queue, and a monitor pops and compares after every clock edge.
module tb_program_counter_rs;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  BC;
    logic [2:0]  PS;
    logic [15:0] D;
    logic [15:0] A;
    logic [3:0]  AA;
    logic [3:0]  BA;
    logic [5:0]  pc;
    logic [2:0]  stack_count;
    logic        stack_overflow;
    logic        stack_underflow;

    // {pc, stack_count, overflow, underflow}
    logic [10:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    program_counter_rs dut (
        .clk(clk), .reset(reset), .stall(stall), .BC(BC), .PS(PS),
        .D(D), .A(A), .AA(AA), .BA(BA), .pc(pc), .stack_count(stack_count),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    task automatic step(input string nm, input logic rst, input logic st,
                        input logic [1:0] bc, input logic [2:0] ps,
                        input logic [15:0] d, input logic [15:0] a, input logic [7:0] off,
                        input logic [5:0] epc, input logic [2:0] ecnt,
                        input logic eovf, input logic eunf);
        @(negedge clk);
        reset = rst; stall = st; BC = bc; PS = ps; D = d; A = a;
        AA = off[7:4]; BA = off[3:0];
        exp_q.push_back({epc, ecnt, eovf, eunf});
        name_q.push_back(nm);
    endtask

    // Monitor: every edge produces a new registered state to compare.
    initial begin
        logic [10:0] exp;
        logic [10:0] got;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {pc, stack_count, stack_overflow, stack_underflow};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s: got pc=%0d cnt=%0d ovf=%b unf=%b, want pc=%0d cnt=%0d ovf=%b unf=%b",
                             nm, got[10:5], got[4:2], got[1], got[0],
                             exp[10:5], exp[4:2], exp[1], exp[0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; BC = 2'd0; PS = 3'd0;
        D = '0; A = '0; AA = '0; BA = '0;

        //     name           rst st  BC  PS   D         A         off     pc cnt o  u
        step("reset",          1, 0, 2'd3, 3'd1, 16'h0000, 16'h0000, 8'h00,  0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            step("inc_run",    0, 0, 2'd3, 3'd1, 16'h0000, 16'h0000, 8'h00, 6'(i), 0, 0, 0);
        step("reset_mid",      1, 0, 2'd3, 3'd1, 16'h0000, 16'h0000, 8'h00,  0, 0, 0, 0);
        step("abs_10",         0, 0, 2'd3, 3'd3, 16'h0000, 16'd10,   8'h00, 10, 0, 0, 0);
        step("rel_neg5",       0, 0, 2'd3, 3'd2, 16'h0000, 16'h0000, 8'hFB,  6, 0, 0, 0);
        step("abs_62",         0, 0, 2'd3, 3'd3, 16'h0000, 16'd62,   8'h00, 62, 0, 0, 0);
        step("rel_wrap_up",    0, 0, 2'd3, 3'd2, 16'h0000, 16'h0000, 8'h03,  2, 0, 0, 0);
        step("neg_taken",      0, 0, 2'd2, 3'd3, 16'h8000, 16'h0025, 8'h00, 37, 0, 0, 0);
        step("neg_not_taken",  0, 0, 2'd2, 3'd3, 16'h7FFF, 16'h0025, 8'h00, 38, 0, 0, 0);
        step("zero_hold",      0, 0, 2'd0, 3'd0, 16'h0000, 16'h0000, 8'h00, 38, 0, 0, 0);
        step("zero_not_taken", 0, 0, 2'd0, 3'd0, 16'h0001, 16'h0000, 8'h00, 39, 0, 0, 0);
        step("nzero_not_taken",0, 0, 2'd1, 3'd3, 16'h0000, 16'd4,    8'h00, 40, 0, 0, 0);
        step("nzero_taken",    0, 0, 2'd1, 3'd3, 16'h0003, 16'd4,    8'h00,  4, 0, 0, 0);
        step("call_abs_20",    0, 0, 2'd3, 3'd5, 16'h0000, 16'd20,   8'h00, 20, 1, 0, 0);
        step("ret_to_5",       0, 0, 2'd3, 3'd6, 16'h0000, 16'h0000, 8'h00,  5, 0, 0, 0);
        step("abs_4",          0, 0, 2'd3, 3'd3, 16'h0000, 16'd4,    8'h00,  4, 0, 0, 0);
        step("nest_call_abs",  0, 0, 2'd3, 3'd5, 16'h0000, 16'd20,   8'h00, 20, 1, 0, 0);
        step("nest_call_rel",  0, 0, 2'd3, 3'd4, 16'h0000, 16'h0000, 8'h09, 30, 2, 0, 0);
        step("nest_ret_21",    0, 0, 2'd3, 3'd6, 16'h0000, 16'h0000, 8'h00, 21, 1, 0, 0);
        step("nest_ret_5",     0, 0, 2'd3, 3'd6, 16'h0000, 16'h0000, 8'h00,  5, 0, 0, 0);
        step("call_not_taken", 0, 0, 2'd0, 3'd5, 16'h0001, 16'd50,   8'h00,  6, 0, 0, 0);
        step("ret_not_taken",  0, 0, 2'd0, 3'd6, 16'h0007, 16'h0000, 8'h00,  7, 0, 0, 0);
        step("reserved_ps",    0, 0, 2'd3, 3'd7, 16'h0000, 16'd50,   8'h00,  8, 0, 0, 0);
        step("taken_hold",     0, 0, 2'd3, 3'd0, 16'h0000, 16'h0000, 8'h00,  8, 0, 0, 0);
        step("fill_call_1",    0, 0, 2'd3, 3'd5, 16'h0000, 16'd16,   8'h00, 16, 1, 0, 0);
        step("fill_call_2",    0, 0, 2'd3, 3'd4, 16'h0000, 16'h0000, 8'h02, 19, 2, 0, 0);
        step("fill_call_3",    0, 0, 2'd3, 3'd5, 16'h0000, 16'd40,   8'h00, 40, 3, 0, 0);
        step("fill_call_4",    0, 0, 2'd3, 3'd4, 16'h0000, 16'h0000, 8'hFF, 40, 4, 0, 0);
        step("overflow_call",  0, 0, 2'd3, 3'd5, 16'h0000, 16'd50,   8'h00, 41, 4, 1, 0);
        step("drain_ret_1",    0, 0, 2'd3, 3'd6, 16'h0000, 16'h0000, 8'h00, 41, 3, 1, 0);
        step("drain_ret_2",    0, 0, 2'd3, 3'd6, 16'h0000, 16'h0000, 8'h00, 20, 2, 1, 0);
        step("drain_ret_3",    0, 0, 2'd3, 3'd6, 16'h0000, 16'h0000, 8'h00, 17, 1, 1, 0);
        step("drain_ret_4",    0, 0, 2'd3, 3'd6, 16'h0000, 16'h0000, 8'h00,  9, 0, 1, 0);
        step("underflow_ret",  0, 0, 2'd3, 3'd6, 16'h0000, 16'h0000, 8'h00, 10, 0, 1, 1);
        step("flags_sticky",   0, 0, 2'd3, 3'd1, 16'h0000, 16'h0000, 8'h00, 11, 0, 1, 1);
        step("stall_call",     0, 1, 2'd3, 3'd5, 16'h0000, 16'd33,   8'h00, 11, 0, 1, 1);
        step("stall_ret",      0, 1, 2'd3, 3'd6, 16'h0000, 16'h0000, 8'h00, 11, 0, 1, 1);
        step("unstall_call",   0, 0, 2'd3, 3'd5, 16'h0000, 16'd33,   8'h00, 33, 1, 1, 1);
        step("unstall_ret",    0, 0, 2'd3, 3'd6, 16'h0000, 16'h0000, 8'h00, 12, 0, 1, 1);
        step("reset_over_stall",1, 1, 2'd3, 3'd1, 16'h0000, 16'h0000, 8'h00, 0, 0, 0, 0);
        step("inc_after_rst",  0, 0, 2'd3, 3'd1, 16'h0000, 16'h0000, 8'h00,  1, 0, 0, 0);
        step("rel_wrap_down",  0, 0, 2'd3, 3'd2, 16'h0000, 16'h0000, 8'hFD, 63, 0, 0, 0);
        step("abs_upper_bits", 0, 0, 2'd3, 3'd3, 16'h0000, 16'hFFC7, 8'h00,  7, 0, 0, 0);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
